// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: shared types for the iterative multiply/divide unit.
//   mdu_op_e    - 2-bit operation codes (MULT, MULTU, DIV, DIVU)
//   mdu_state_e - control FSM states (IDLE, CALC, FIX)
//   op_is_div / op_is_signed - opcode decode helpers
package mdu_iter_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/result bundle between the EX stage and the MDU.
//   start, op[1:0], cancel, a, b : request side (master drives)
//   busy, done, hi, lo           : result side (slave drives)
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic             cancel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, cancel, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, cancel, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational two's-complement correction of magnitude results.
//   neg_p_i : negate product / quotient
//   neg_r_i : negate remainder
//   prod_i  : 2*WIDTH product magnitude   -> prod_o
//   quo_i   : WIDTH quotient magnitude    -> quo_o
//   rem_i   : WIDTH remainder magnitude   -> rem_o
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic               neg_p_i,
    input  logic               neg_r_i,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   quo_i,
    input  logic [WIDTH-1:0]   rem_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   quo_o,
    output logic [WIDTH-1:0]   rem_o
);
    assign prod_o = neg_p_i ? ('0 - prod_i) : prod_i;
    assign quo_o  = neg_p_i ? ('0 - quo_i)  : quo_i;
    assign rem_o  = neg_r_i ? ('0 - rem_i)  : rem_i;
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, results in HI/LO.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mdu_iter_if.slave: start/op/cancel/a/b in, busy/done/hi/lo out
// Build option: define MDU_FAST_MUL_EN to route MULT/MULTU through a
// single-cycle multiplier (IDLE -> FIX); divides stay iterative.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic       clk,
    input logic       rst,
    mdu_iter_if.slave bus
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_p_q, neg_p_d;
    logic               neg_r_q, neg_r_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    // mult: {partial product, remaining multiplier bits}; div: low half is quotient/dividend
    logic [2*WIDTH-1:0] acc_q, acc_d;

    // Accept-time operand decode
    logic             start_div, op_signed, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign start_div = op_is_div(mdu_op_e'(bus.op));
    assign op_signed = op_is_signed(mdu_op_e'(bus.op));
    assign a_neg     = op_signed & bus.a[WIDTH-1];
    assign b_neg     = op_signed & bus.b[WIDTH-1];
    assign b_zero    = (bus.b == '0);
    assign abs_a     = a_neg ? ('0 - bus.a) : bus.a;
    assign abs_b     = b_neg ? ('0 - bus.b) : bus.b;

    // Shift-add step
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    assign mul_addend = acc_q[0] ? mag_a_q : '0;
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

    // Restoring-division step; remainder stays below the divisor so WIDTH bits hold it
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mag_b_q});
    assign div_diff  = div_shift[WIDTH-1:0] - mag_b_q;

    logic [2*WIDTH-1:0] prod_src, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MDU_FAST_MUL_EN
    assign prod_src = {{WIDTH{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, mag_b_q};
`else
    assign prod_src = acc_q;
`endif

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .neg_p_i (neg_p_q),
        .neg_r_i (neg_r_q),
        .prod_i  (prod_src),
        .quo_i   (acc_q[WIDTH-1:0]),
        .rem_i   (rem_q),
        .prod_o  (prod_fix),
        .quo_o   (quo_fix),
        .rem_o   (rem_fix)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_p_d  = neg_p_q;
        neg_r_d  = neg_r_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    is_div_d = start_div;
                    // divide-by-zero keeps the all-ones quotient un-negated
                    neg_p_d  = (a_neg ^ b_neg) & ~(start_div & b_zero);
                    neg_r_d  = a_neg;
                    mag_a_d  = abs_a;
                    mag_b_d  = abs_b;
                    acc_d    = {{WIDTH{1'b0}}, (start_div ? abs_a : abs_b)};
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_CALC;
`ifdef MDU_FAST_MUL_EN
                    if (!start_div) state_d = S_FIX;
`endif
                end
            end
            S_CALC: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            done_q   <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_p_q  <= neg_p_d;
            neg_r_q  <= neg_r_d;
            done_q   <= done_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (WIDTH=32) against an
// arithmetic reference model; honours MDU_FAST_MUL_EN for multiply latency.
module tb_mdu_iter;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mdu_iter_if #(.WIDTH(W)) bus();

    mdu_iter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on the MIPS semantics
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint     sa, sb;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        if (op == 2'b00) p = sa * sb;
        if (op == 2'b01) p = {32'b0, a} * {32'b0, b};
        if (op == 2'b00 || op == 2'b01) begin
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end else begin
            hi = a % b;
            lo = a / b;
        end
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
`ifdef MDU_FAST_MUL_EN
        if (op == 2'b00 || op == 2'b01) return 2;
`endif
        return W + 2;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Runs one operation from the current negedge; returns in the done cycle.
    // poke_cyc > 0 raises a spurious start (junk operands) for two cycles there.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int poke_cyc);
        logic [31:0] eh, el, hi0, lo0;
        int elat, lat, bad;
        model(op, a, b, eh, el);
        elat = exp_lat(op);
        hi0 = bus.hi;
        lo0 = bus.lo;
        lat = -1;
        bad = 0;
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0;
                bus.op = 2'($urandom_range(0, 3));
                bus.a = $urandom;
                bus.b = $urandom;
            end
            if (poke_cyc > 0 && c == poke_cyc) bus.start = 1'b1;
            if (poke_cyc > 0 && c == poke_cyc + 2) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = c;
                if (bus.busy !== 1'b0) bad++;
            end else begin
                if (bus.busy !== (c < elat)) bad++;
                if (bus.hi !== hi0 || bus.lo !== lo0) bad++;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (lat !== elat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s busy/hold profile: %0d bad cycles, expected 0", name, bad);
        end
        checks++;
        if (bus.hi !== eh) begin
            failures++;
            $display("FAIL %s hi: got %h expected %h (a=%h b=%h)", name, bus.hi, eh, a, b);
        end
        checks++;
        if (bus.lo !== el) begin
            failures++;
            $display("FAIL %s lo: got %h expected %h (a=%h b=%h)", name, bus.lo, el, a, b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset busy/done: got %b/%b expected 0/0", bus.busy, bus.done);
        end
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset hi/lo: got %h/%h expected 0/0", bus.hi, bus.lo);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        do_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 0);
        do_op("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("divu_7by2", 2'b11, 32'd7, 32'd2, 0);
        do_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("divu_by0", 2'b11, 32'd5, 32'd0, 0);
        do_op("div_neg_by0", 2'b10, 32'hFFFF_FFF0, 32'd0, 0);
        do_op("multu_3x5", 2'b01, 32'd3, 32'd5, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = pick();
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            do_op("random", 2'($urandom_range(0, 3)), ra, rb, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_cancel(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int cancel_cyc);
        logic [31:0] hi0, lo0;
        int dones;
        hi0 = bus.hi;
        lo0 = bus.lo;
        dones = 0;
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        for (int c = 1; c <= cancel_cyc; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.done === 1'b1) dones++;
            if (c == cancel_cyc) bus.cancel = 1'b1;
        end
        @(negedge clk);
        bus.cancel = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy after cancel: got %b expected 0", name, bus.busy);
        end
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL %s done pulses: got %0d expected 0", name, dones);
        end
        checks++;
        if (bus.hi !== hi0 || bus.lo !== lo0) begin
            failures++;
            $display("FAIL %s hi/lo retained: got %h/%h expected %h/%h", name, bus.hi, bus.lo, hi0, lo0);
        end
    endtask

    task automatic test_aborts();
        do_op("preload_divu", 2'b11, 32'd7, 32'd2, 0);
        @(negedge clk);
        test_cancel("cancel_calc", 2'b11, 32'd100, 32'd3, 10);
        test_cancel("cancel_fix", 2'b01, 32'd12345, 32'd999, exp_lat(2'b01) - 1);
    endtask

    task automatic test_start_while_busy();
        int dones;
        dones = 0;
        do_op("start_while_busy", 2'b11, 32'd1000, 32'd7, 5);
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL ignored_start activity: got %0d busy/done cycles expected 0", dones);
        end
    endtask

    task automatic test_start_cancel_same();
        logic [31:0] hi0, lo0;
        int act;
        hi0 = bus.hi;
        lo0 = bus.lo;
        act = 0;
        bus.start = 1'b1;
        bus.cancel = 1'b1;
        bus.op = 2'b01;
        bus.a = 32'd9;
        bus.b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.busy === 1'b1 || bus.done === 1'b1) act++;
            @(negedge clk);
        end
        checks++;
        if (act !== 0) begin
            failures++;
            $display("FAIL start_cancel_same activity: got %0d busy/done cycles expected 0", act);
        end
        checks++;
        if (bus.hi !== hi0 || bus.lo !== lo0) begin
            failures++;
            $display("FAIL start_cancel_same hi/lo: got %h/%h expected %h/%h", bus.hi, bus.lo, hi0, lo0);
        end
    endtask

    task automatic test_reset_mid();
        do_op("preload_rst", 2'b11, 32'd7, 32'd2, 0);
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.a = 32'd500;
        bus.b = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid busy/done: got %b/%b expected 0/0", bus.busy, bus.done);
        end
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid hi/lo: got %h/%h expected 0/0", bus.hi, bus.lo);
        end
        do_op("after_reset", 2'b00, 32'hFFFF_FFFF, 32'd2, 0);
    endtask

    task automatic test_back_to_back();
        // each call starts in the previous done cycle
        do_op("b2b_1", 2'b10, 32'd77, 32'hFFFF_FFF6, 0);
        do_op("b2b_2", 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
        do_op("b2b_3", 2'b11, 32'hDEAD_BEEF, 32'd16, 0);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_directed();
        test_random();
        test_aborts();
        test_start_while_busy();
        test_start_cancel_same();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parametrised iterative multiply/divide unit, the sequential successor to the single-cycle ALU. It executes MIPS MULT, MULTU, DIV and DIVU at one bit per cycle and writes results into internal HI/LO registers. It sits in the EX stage beside the ALU. The pipeline stalls on `busy`, and HI/LO feed MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
cancel  input  1  flush (exception/branch kill); aborts the current operation.
a  input  WIDTH  rs operand (multiplicand / dividend); sampled with start.
b  input  WIDTH  rt operand (multiplier / divisor); sampled with start.
busy  output  1  high while an operation is in flight (CALC or FIX).
done  output  1  one-cycle pulse when HI/LO are updated.
hi  output  WIDTH  mult: upper product; div: remainder.
lo  output  WIDTH  mult: lower product; div: quotient.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, all internal registers 0. Reset mid-operation aborts it; HI/LO are cleared.
- States:
  - IDLE: start=1 and cancel=0 → CALC.
  - CALC: counter counts from 0 to WIDTH-1, then → FIX.
  - FIX → IDLE.
- On accept, register the operand magnitudes: for signed ops take |a| and |b| in WIDTH bits, so -2^(WIDTH-1) maps to 2^(WIDTH-1). Also register the sign flags: product sign = a^b sign; quotient sign = a^b sign; remainder sign = a sign. Unsigned ops set the sign flags to 0.
- CALC multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
- CALC divide: restoring division, one quotient bit per cycle, using a (WIDTH+1)-bit partial remainder.
- FIX: apply two's-complement negation per the sign flags. At the FIX→IDLE edge, write hi/lo and assert done for exactly one cycle.
- Latency: with start accepted at edge 0, done is high in the cycle after edge WIDTH+1, i.e. WIDTH+2 cycles. busy is high from the cycle after the accept until the cycle done is high (busy=0 when done=1).
- Divide by zero (b==0, signed or unsigned): lo = all ones, hi = a unchanged. Normal latency applies; no exception is raised.
- Signed overflow (-2^(WIDTH-1) / -1): lo = 0x8000_0000 (for WIDTH=32), hi = 0. This falls out of the magnitude datapath without special-casing.
- start while busy: ignored; op/a/b are not sampled.
- cancel in IDLE with start: cancel wins and nothing starts.
- cancel in CALC/FIX: → IDLE at the next edge. busy drops, no done, hi/lo retain their previous values.
- start in the done cycle: accepted (state is IDLE).
- hi/lo hold their value between completions. They change only on done or reset.

Optional Feature:
MDU_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle WIDTH×WIDTH multiplier on the registered magnitudes and skip CALC (IDLE→FIX). done is high 2 cycles after start; busy is high 1 cycle. DIV/DIVU are unchanged.
- Undefined: all ops take the iterative path with WIDTH+2 latency.

Decomposition:
- Shared defines.vh additions:
  - MDU_OP_MULT/MULTU/DIV/DIVU (2-bit codes).
  - MDU_IDLE/MDU_CALC/MDU_FIX state encodings.
- Sub-module mdu_sign_fix: combinational conditional negation of the 2*WIDTH product, or of the quotient/remainder, given the sign flags. Used in FIX.

Test Plan:
All cases use WIDTH=32.
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF → hi=0xFFFFFFFE lo=0x00000001; done exactly 34 cycles after start; busy high for cycles 1..33.
2. MULT a=0xFFFFFFFD(-3) b=7 → hi=0xFFFFFFFF lo=0xFFFFFFEB(-21). MULT a=0x80000000 b=0x80000000 → hi=0x40000000 lo=0.
3. DIV a=0xFFFFFFF9(-7) b=2 → lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU a=7 b=2 → lo=3 hi=1.
4. DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000 hi=0. DIVU a=5 b=0 → lo=0xFFFFFFFF hi=5, at normal latency.
5. Abort cases:
   - Preload hi/lo via DIVU 7/2, then start DIVU 100/3 and assert cancel on cycle 10 → no done; hi=1 lo=3 retained.
   - start asserted while busy → ignored.
   - start+cancel in the same cycle → busy stays 0.
6. Reset and fast path:
   - rst asserted mid-CALC → next cycle busy=0, hi=lo=0.
   - With MDU_FAST_MUL_EN: MULTU 3×5 → done 2 cycles after start, lo=15 hi=0.
